// File: rtl/ren_setup_edge_seq_if.sv
// ren_setup_edge_seq_if: triangle-in / edge-setup-out bundle between vertex fetch and rasteriser
interface ren_setup_edge_seq_if #(
  parameter int W = 22,
  parameter int STEP_W = 16
);
  logic i_en, i_busy;
  logic [1:0] i_cull_mode;
  logic signed [W-1:0] i_vtx0_x, i_vtx0_y, i_vtx1_x, i_vtx1_y, i_vtx2_x, i_vtx2_y;
  logic signed [W-1:0] o_e0_a, o_e0_b, o_e0_c, o_e1_a, o_e1_b, o_e1_c, o_e2_a, o_e2_b, o_e2_c;
  logic signed [W-1:0] o_area2, o_min_x, o_min_y;
  logic [STEP_W-1:0] o_steps_x, o_steps_y, o_tri_cnt, o_cull_cnt;
  logic o_valid, o_idle, o_cull;
  modport master (
    output i_en, i_busy, i_cull_mode, i_vtx0_x, i_vtx0_y, i_vtx1_x, i_vtx1_y, i_vtx2_x, i_vtx2_y,
    input o_e0_a, o_e0_b, o_e0_c, o_e1_a, o_e1_b, o_e1_c, o_e2_a, o_e2_b, o_e2_c,
    input o_area2, o_min_x, o_min_y, o_steps_x, o_steps_y, o_tri_cnt, o_cull_cnt, o_valid, o_idle, o_cull
  );
  modport slave (
    input i_en, i_busy, i_cull_mode, i_vtx0_x, i_vtx0_y, i_vtx1_x, i_vtx1_y, i_vtx2_x, i_vtx2_y,
    output o_e0_a, o_e0_b, o_e0_c, o_e1_a, o_e1_b, o_e1_c, o_e2_a, o_e2_b, o_e2_c,
    output o_area2, o_min_x, o_min_y, o_steps_x, o_steps_y, o_tri_cnt, o_cull_cnt, o_valid, o_idle, o_cull
  );
endinterface

// File: rtl/ren_setup_edge_seq.sv
// ren_setup_edge_seq: triangle setup on one shared multiplier - edge equations, double area,
// viewport-clamped bounding box, face/degenerate/offscreen culling and statistics counters
module ren_setup_edge_seq #(
  parameter int W = 22,
  parameter int FRAC = 11,
  parameter int STEP_W = 16,
  parameter int VP_W = 640,
  parameter int VP_H = 480
) (
  input logic clk,
  input logic rstn,
  ren_setup_edge_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL, AREA, BBOX, OUT} state_t;
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] XM = W'(VP_W - 1);
  localparam logic signed [W-1:0] YM = W'(VP_H - 1);
  state_t state, state_nx;
  logic signed [W-1:0] vx [3], vy [3], ea [3], eb [3], ec [3];
  logic signed [W-1:0] area2, min_x, min_y;
  logic [STEP_W-1:0] steps_x, steps_y, tri_cnt, cull_cnt;
  logic [1:0] mode, k, j;
  logic [2:0] idx;
  logic cull, cull_a, cull_b, cull_nx;
  logic signed [W-1:0] opa, opb, prod_s, ec_sub, area_s;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0] fx [3], fy [3];
  logic signed [W-1:0] lo_x, hi_x, lo_y, hi_y, cl_lo_x, cl_hi_x, cl_lo_y, cl_hi_y;
  function automatic logic signed [W-1:0] sat(input logic signed [2*W-1:0] v);
    return (&v[2*W-1:W-1] || ~|v[2*W-1:W-1]) ? v[W-1:0] : (v[2*W-1] ? SMIN : SMAX);
  endfunction
  function automatic logic signed [2*W-1:0] sx(input logic signed [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction
  function automatic logic signed [W-1:0] mn(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic signed [W-1:0] mx(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v, input logic signed [W-1:0] hi);
    return v < 0 ? '0 : (v > hi ? hi : v);
  endfunction
  // idx[2:1] selects edge k=(i,j); even idx issues xi*yj, odd issues xj*yi
  assign k = idx[2:1];
  assign j = k == 2'd2 ? 2'd0 : k + 2'd1;
  assign opa = idx[0] ? vx[j] : vx[k];
  assign opb = idx[0] ? vy[k] : vy[j];
  assign prod = sx(opa) * sx(opb);
  assign prod_s = sat(prod >>> FRAC);
  assign ec_sub = sat(sx(ec[k]) - sx(prod_s));
  assign area_s = sat(sx(ec[0]) + sx(ec[1]) + sx(ec[2]));
  assign cull_a = area_s == 0 || (mode == 2'd1 && area_s < 0) || (mode == 2'd2 && area_s > 0);
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      fx[n] = vx[n] >>> FRAC;
      fy[n] = vy[n] >>> FRAC;
    end
  end
  assign lo_x = mn(mn(fx[0], fx[1]), fx[2]);
  assign hi_x = mx(mx(fx[0], fx[1]), fx[2]);
  assign lo_y = mn(mn(fy[0], fy[1]), fy[2]);
  assign hi_y = mx(mx(fy[0], fy[1]), fy[2]);
  assign cl_lo_x = clamp(lo_x, XM);
  assign cl_hi_x = clamp(hi_x, XM);
  assign cl_lo_y = clamp(lo_y, YM);
  assign cl_hi_y = clamp(hi_y, YM);
  assign cull_b = hi_x < 0 || lo_x > XM || hi_y < 0 || lo_y > YM;
  assign cull_nx = (state == AREA && cull_a) || (state == BBOX && cull_b);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.i_en ? MUL : IDLE;
      MUL: state_nx = idx == 3'd5 ? AREA : MUL;
      AREA: state_nx = cull_a ? IDLE : BBOX;
      BBOX: state_nx = cull_b ? IDLE : OUT;
      OUT: state_nx = bus.i_busy ? OUT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.o_idle = state == IDLE;
    bus.o_valid = state == OUT;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int n = 0; n < 3; n++) begin
        vx[n] <= '0;
        vy[n] <= '0;
        ea[n] <= '0;
        eb[n] <= '0;
        ec[n] <= '0;
      end
      {area2, min_x, min_y, steps_x, steps_y, tri_cnt, cull_cnt, mode, idx, cull} <= '0;
    end else begin
      cull <= cull_nx;
      if (cull_nx) cull_cnt <= cull_cnt + STEP_W'(1);
      if (state == IDLE && bus.i_en) begin
        vx[0] <= bus.i_vtx0_x;
        vy[0] <= bus.i_vtx0_y;
        vx[1] <= bus.i_vtx1_x;
        vy[1] <= bus.i_vtx1_y;
        vx[2] <= bus.i_vtx2_x;
        vy[2] <= bus.i_vtx2_y;
        mode <= bus.i_cull_mode;
        idx <= '0;
        tri_cnt <= tri_cnt + STEP_W'(1);
      end
      if (state == MUL) begin
        idx <= idx + 3'd1;
        ea[k] <= vy[k] - vy[j];
        eb[k] <= vx[j] - vx[k];
        ec[k] <= idx[0] ? ec_sub : prod_s;
      end
      if (state == AREA) area2 <= area_s;
      if (state == BBOX) begin
        min_x <= cl_lo_x <<< FRAC;
        min_y <= cl_lo_y <<< FRAC;
        steps_x <= STEP_W'(cl_hi_x - cl_lo_x) + STEP_W'(1);
        steps_y <= STEP_W'(cl_hi_y - cl_lo_y) + STEP_W'(1);
      end
    end
  assign bus.o_e0_a = ea[0];
  assign bus.o_e0_b = eb[0];
  assign bus.o_e0_c = ec[0];
  assign bus.o_e1_a = ea[1];
  assign bus.o_e1_b = eb[1];
  assign bus.o_e1_c = ec[1];
  assign bus.o_e2_a = ea[2];
  assign bus.o_e2_b = eb[2];
  assign bus.o_e2_c = ec[2];
  assign bus.o_area2 = area2;
  assign bus.o_min_x = min_x;
  assign bus.o_min_y = min_y;
  assign bus.o_steps_x = steps_x;
  assign bus.o_steps_y = steps_y;
  assign bus.o_tri_cnt = tri_cnt;
  assign bus.o_cull_cnt = cull_cnt;
  assign bus.o_cull = cull;
endmodule

// File: tb/tb_ren_setup_edge_seq.sv
// tb_ren_setup_edge_seq: directed vector table for ren_setup_edge_seq plus back-pressure
// and mid-flight reset sequences
module tb_ren_setup_edge_seq;
  localparam int F = 2048;
  localparam int SMAX = 2097151;
  localparam int SMIN = -2097152;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0, bad = 0, et = 0, ecn = 0;
  ren_setup_edge_seq_if #(.W(22), .STEP_W(16)) bus ();
  ren_setup_edge_seq #(.W(22), .FRAC(11), .STEP_W(16), .VP_W(640), .VP_H(480)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    int x0, y0, x1, y1, x2, y2, mode, cul, cyc;
    int a0, b0, c0, a1, b1, c1, a2, b2, c2;
    int area, mx, my, sx, sy, bb;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t t, input logic en);
    bus.i_vtx0_x = 22'(t.x0);
    bus.i_vtx0_y = 22'(t.y0);
    bus.i_vtx1_x = 22'(t.x1);
    bus.i_vtx1_y = 22'(t.y1);
    bus.i_vtx2_x = 22'(t.x2);
    bus.i_vtx2_y = 22'(t.y2);
    bus.i_cull_mode = 2'(t.mode);
    bus.i_en = en;
  endtask
  // returns the first cycle after accept on which o_valid or o_cull is seen, 0 on timeout
  task automatic wait_event(output int ev, output logic kind);
    ev = 0;
    kind = 1'b0;
    for (int cyc = 1; cyc < 20 && ev == 0; cyc++) begin
      @(negedge clk);
      if (bus.o_valid || bus.o_cull) begin
        ev = cyc;
        kind = bus.o_cull;
      end else @(posedge clk);
    end
  endtask
  task automatic run(input vec_t t, input int n);
    int ev;
    logic kind;
    @(posedge clk); #1;
    drive(t, 1'b1);
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    et++;
    if (t.cul != 0) ecn++;
    wait_event(ev, kind);
    chk($sformatf("v%0d event_cycle", n), ev, t.cyc);
    chk($sformatf("v%0d cull", n), int'(kind), t.cul);
    chk($sformatf("v%0d valid", n), int'(bus.o_valid), 1 - t.cul);
    chk($sformatf("v%0d e0a", n), int'(bus.o_e0_a), t.a0);
    chk($sformatf("v%0d e0b", n), int'(bus.o_e0_b), t.b0);
    chk($sformatf("v%0d e0c", n), int'(bus.o_e0_c), t.c0);
    chk($sformatf("v%0d e1a", n), int'(bus.o_e1_a), t.a1);
    chk($sformatf("v%0d e1b", n), int'(bus.o_e1_b), t.b1);
    chk($sformatf("v%0d e1c", n), int'(bus.o_e1_c), t.c1);
    chk($sformatf("v%0d e2a", n), int'(bus.o_e2_a), t.a2);
    chk($sformatf("v%0d e2b", n), int'(bus.o_e2_b), t.b2);
    chk($sformatf("v%0d e2c", n), int'(bus.o_e2_c), t.c2);
    chk($sformatf("v%0d area2", n), int'(bus.o_area2), t.area);
    chk($sformatf("v%0d tri_cnt", n), int'(bus.o_tri_cnt), et);
    chk($sformatf("v%0d cull_cnt", n), int'(bus.o_cull_cnt), ecn);
    if (t.bb != 0) begin
      chk($sformatf("v%0d min_x", n), int'(bus.o_min_x), t.mx);
      chk($sformatf("v%0d min_y", n), int'(bus.o_min_y), t.my);
      chk($sformatf("v%0d steps_x", n), int'(bus.o_steps_x), t.sx);
      chk($sformatf("v%0d steps_y", n), int'(bus.o_steps_y), t.sy);
    end
    @(negedge clk);
    chk($sformatf("v%0d after_cull", n), int'(bus.o_cull), 0);
    chk($sformatf("v%0d after_valid", n), int'(bus.o_valid), 0);
    chk($sformatf("v%0d after_idle", n), int'(bus.o_idle), 1);
  endtask
  initial begin
    int ev;
    logic kind;
    bus.i_busy = 1'b0;
    tv[0] = '{F, F/2, F, F/2, 2*F, 4*F, 0, 1, 8, 0, 0, 0, -7*F/2, F, 3*F, 7*F/2, -F, -3*F, 0, 0, 0, 0, 0, 0};
    tv[1] = '{0, 0, 4*F, 0, 0, 4*F, 0, 0, 9, 0, 4*F, 0, -4*F, -4*F, 16*F, 4*F, 0, 0, 16*F, 0, 0, 5, 5, 1};
    tv[2] = '{0, 0, 0, 4*F, 4*F, 0, 1, 1, 8, -4*F, 0, 0, 4*F, 4*F, -16*F, 0, -4*F, 0, -16*F, 0, 0, 0, 0, 0};
    tv[3] = '{0, 0, 0, 4*F, 4*F, 0, 2, 0, 9, -4*F, 0, 0, 4*F, 4*F, -16*F, 0, -4*F, 0, -16*F, 0, 0, 5, 5, 1};
    tv[4] = '{0, 0, 4*F, 0, 0, 4*F, 2, 1, 8, 0, 4*F, 0, -4*F, -4*F, 16*F, 4*F, 0, 0, 16*F, 0, 0, 0, 0, 0};
    tv[5] = '{0, 0, 4*F, 0, 0, 4*F, 3, 0, 9, 0, 4*F, 0, -4*F, -4*F, 16*F, 4*F, 0, 0, 16*F, 0, 0, 5, 5, 1};
    tv[6] = '{-3*F, 5*F/2, 700*F, 5*F/2, 10*F, 470*F, 0, 0, 9, 0, 703*F, SMIN, -935*F/2, -690*F, 2045951, 935*F/2, -13*F, SMAX, 2045950, 0, 2*F, 640, 469, 1};
    tv[7] = '{-10*F, 0, -5*F, 0, -10*F, 5*F, 0, 1, 9, 0, 5*F, 0, -5*F, -5*F, -25*F, 5*F, 0, 50*F, 25*F, 0, 0, 0, 0, 0};
    drive(tv[1], 1'b0);
    @(posedge clk); #1;
    chk("rst idle", int'(bus.o_idle), 1);
    chk("rst valid", int'(bus.o_valid), 0);
    chk("rst cull", int'(bus.o_cull), 0);
    chk("rst tri_cnt", int'(bus.o_tri_cnt), 0);
    chk("rst cull_cnt", int'(bus.o_cull_cnt), 0);
    chk("rst area2", int'(bus.o_area2), 0);
    chk("rst steps_x", int'(bus.o_steps_x), 0);
    chk("rst min_y", int'(bus.o_min_y), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) run(tv[i], i);
    bus.i_busy = 1'b1;
    @(posedge clk); #1;
    drive(tv[1], 1'b1);
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    et++;
    wait_event(ev, kind);
    chk("bp event_cycle", ev, 9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(tv[2], 1'b1);
      @(negedge clk);
      chk($sformatf("bp%0d valid", i), int'(bus.o_valid), 1);
      chk($sformatf("bp%0d idle", i), int'(bus.o_idle), 0);
      chk($sformatf("bp%0d area2", i), int'(bus.o_area2), 16*F);
      chk($sformatf("bp%0d e1c", i), int'(bus.o_e1_c), 16*F);
      chk($sformatf("bp%0d steps_x", i), int'(bus.o_steps_x), 5);
      chk($sformatf("bp%0d tri_cnt", i), int'(bus.o_tri_cnt), et);
    end
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    bus.i_busy = 1'b0;
    @(negedge clk);
    chk("bp release valid", int'(bus.o_valid), 1);
    @(negedge clk);
    chk("bp done idle", int'(bus.o_idle), 1);
    chk("bp done valid", int'(bus.o_valid), 0);
    chk("bp done area2 held", int'(bus.o_area2), 16*F);
    @(posedge clk); #1;
    drive(tv[1], 1'b1);
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst idle", int'(bus.o_idle), 1);
    chk("midrst valid", int'(bus.o_valid), 0);
    chk("midrst tri_cnt", int'(bus.o_tri_cnt), 0);
    chk("midrst cull_cnt", int'(bus.o_cull_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    et = 0;
    ecn = 0;
    run(tv[6], 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
